// File: rtl/uart_apb_bridge.sv
// UART-to-APB bridge: 8N1 command frames on rx become single APB transfers; replies go out on tx.
// Optional macro UART_APB_TIMEOUT_EN aborts a stalled ACCESS after TIMEOUT cycles and answers 'T'.
module uart_apb_bridge #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200,
    parameter int TIMEOUT  = 255
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        rx,
    output logic        tx,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [7:0]  PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic        busy
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    localparam logic [7:0] CH_W = 8'h57;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_K = 8'h4B;
    localparam logic [7:0] CH_E = 8'h45;
    localparam logic [7:0] CH_Q = 8'h3F;

    typedef enum logic [3:0] {
        S_CMD, S_ADDR, S_D0, S_D1, S_D2, S_D3, S_SETUP, S_ACCESS, S_RESP
    } state_t;

    state_t          state, state_nx;
    logic            rx_meta, rx_s, rx_q;
    logic            rx_on, rx_en, rx_valid, rx_ferr;
    logic [3:0]      rx_idx;
    logic [CW-1:0]   rx_cnt;
    logic [7:0]      rx_byte;
    logic            tx_load;
    logic [31:0]     load_data;
    logic [1:0]      load_more;
    logic [9:0]      tx_frame;
    logic [3:0]      tx_bits;
    logic [CW-1:0]   tx_cnt;
    logic [23:0]     resp_data;
    logic [1:0]      resp_left;
    logic            tmo_hit;

    assign rx_en   = (state == S_CMD) || (state == S_ADDR) || (state == S_D0) ||
                     (state == S_D1) || (state == S_D2) || (state == S_D3);
    assign PSEL    = (state == S_SETUP) || (state == S_ACCESS);
    assign PENABLE = (state == S_ACCESS);
    assign busy    = (state != S_CMD);
    assign tx      = (tx_bits != 4'd0) ? tx_frame[0] : 1'b1;

    // Receiver: rx_idx 0 is the start bit (checked at half a bit), 1..8 data, 9 stop.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_q     <= 1'b1;
            rx_on    <= 1'b0;
            rx_idx   <= 4'd0;
            rx_cnt   <= '0;
            rx_byte  <= 8'h00;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            rx_q     <= rx_s;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (!rx_on) begin
                if (rx_en && rx_q && !rx_s) begin
                    rx_on  <= 1'b1;
                    rx_idx <= 4'd0;
                    rx_cnt <= '0;
                end
            end else if (rx_idx == 4'd0) begin
                if (rx_cnt == HALF_M1) begin
                    rx_cnt <= '0;
                    if (rx_s) rx_on  <= 1'b0;
                    else      rx_idx <= 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
            end else if (rx_cnt == DIV_M1) begin
                rx_cnt <= '0;
                if (rx_idx == 4'd9) begin
                    rx_on    <= 1'b0;
                    rx_valid <= rx_s;
                    rx_ferr  <= !rx_s;
                end else begin
                    rx_byte <= {rx_s, rx_byte[7:1]};
                    rx_idx  <= rx_idx + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + CW'(1);
            end
        end
    end

`ifdef UART_APB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                tmo_cnt <= 16'd0;
        else if (state == S_ACCESS)  tmo_cnt <= tmo_cnt + 16'd1;
        else                         tmo_cnt <= 16'd0;
    end
    assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
    // Without the counter ACCESS never aborts; TIMEOUT is only legal as 1..65535, so this is 0.
    assign tmo_hit = (TIMEOUT == 0);
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= S_CMD;
        else          state <= state_nx;
    end

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path leaves a latch behind.
        state_nx  = state;
        tx_load   = 1'b0;
        load_data = 32'h0;
        load_more = 2'd0;
        case (state)
            S_CMD: begin
                if (rx_valid) begin
                    if (rx_byte == CH_W || rx_byte == CH_R) begin
                        state_nx = S_ADDR;
                    end else begin
                        state_nx  = S_RESP;
                        tx_load   = 1'b1;
                        load_data = {24'h0, CH_Q};
                    end
                end
            end
            S_ADDR: begin
                if (rx_ferr)       state_nx = S_CMD;
                else if (rx_valid) state_nx = PWRITE ? S_D0 : S_SETUP;
            end
            S_D0, S_D1, S_D2, S_D3: begin
                if (rx_ferr)       state_nx = S_CMD;
                else if (rx_valid) state_nx = (state == S_D3) ? S_SETUP : state_t'(state + 4'd1);
            end
            S_SETUP: state_nx = S_ACCESS;
            S_ACCESS: begin
                if (PREADY) begin
                    state_nx = S_RESP;
                    tx_load  = 1'b1;
                    if (PSLVERR)     load_data = {24'h0, CH_E};
                    else if (PWRITE) load_data = {24'h0, CH_K};
                    else begin
                        load_data = PRDATA;
                        load_more = 2'd3;
                    end
                end else if (tmo_hit) begin
                    state_nx  = S_RESP;
                    tx_load   = 1'b1;
                    load_data = 32'h0000_0054;
                end
            end
            S_RESP: begin
                if (tx_bits == 4'd0) state_nx = S_CMD;
            end
            default: state_nx = S_CMD;
        endcase
    end

    // APB request fields; they only change while bytes are being collected, so they hold afterward.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE <= 1'b0;
            PADDR  <= 8'h00;
            PWDATA <= 32'h0;
        end else if (rx_valid) begin
            case (state)
                S_CMD: begin
                    if (rx_byte == CH_W) begin
                        PWRITE <= 1'b1;
                    end else if (rx_byte == CH_R) begin
                        PWRITE <= 1'b0;
                        PWDATA <= 32'h0;
                    end
                end
                S_ADDR:                 PADDR  <= rx_byte;
                S_D0, S_D1, S_D2, S_D3: PWDATA <= {rx_byte, PWDATA[31:8]};
                default: ;
            endcase
        end
    end

    // Transmitter: a chained byte is loaded on the edge that ends the previous stop bit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_frame  <= '1;
            tx_bits   <= 4'd0;
            tx_cnt    <= '0;
            resp_data <= 24'h0;
            resp_left <= 2'd0;
        end else if (tx_load) begin
            tx_frame  <= {1'b1, load_data[7:0], 1'b0};
            resp_data <= load_data[31:8];
            resp_left <= load_more;
            tx_bits   <= 4'd10;
            tx_cnt    <= '0;
        end else if (tx_bits != 4'd0) begin
            if (tx_cnt == DIV_M1) begin
                tx_cnt <= '0;
                if (tx_bits == 4'd1 && resp_left != 2'd0) begin
                    tx_frame  <= {1'b1, resp_data[7:0], 1'b0};
                    resp_data <= {8'h00, resp_data[23:8]};
                    resp_left <= resp_left - 2'd1;
                    tx_bits   <= 4'd10;
                end else begin
                    tx_frame <= {1'b1, tx_frame[9:1]};
                    tx_bits  <= tx_bits - 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Self-checking bench for uart_apb_bridge: UART host driver, APB completer, tx decoder, reply model.
`timescale 1ns/1ps
module tb_uart_apb_bridge;

    localparam int DIV = 16;
    localparam int TMO = 16;
    localparam time PER = 10;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        rx = 1'b1;
    logic        tx, PSEL, PENABLE, PWRITE, busy;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = 32'h0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    always #(PER / 2) PCLK = ~PCLK;

    uart_apb_bridge #(.CLK_FREQ(1_600_000), .BAUD(100_000), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .rx(rx), .tx(tx),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .busy(busy)
    );

    typedef struct {
        logic [7:0]  addr;
        logic        write;
        logic [31:0] wdata;
        int          setup_n;
        int          acc_n;
        bit          stable;
        time         t_ready;
    } xfer_t;

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        err;
        int          exp_n;
        logic [31:0] exp_bytes;
        bit          exp_xfer;
    } vec_t;

    int tests = 0;
    int failed = 0;

    xfer_t      log_q[$];
    logic [7:0] rx_q[$];
    time        start_q[$];
    time        stop_time = 0;

    int          wait_n = 0;
    logic [31:0] cur_rdata = 32'h0;
    logic        cur_err = 1'b0;
    int          acc_n = 0, setup_n = 0, psel_cycles = 0, last_acc = 0;
    logic [7:0]  cap_addr;
    logic        cap_write;
    logic [31:0] cap_wdata;
    bit          cap_stable;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // APB completer: PREADY after wait_n ACCESS cycles, garbage on PRDATA/PSLVERR otherwise.
    always @(negedge PCLK) begin
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
        if (PSEL) psel_cycles++;
        if (!PSEL) begin
            setup_n = 0;
        end else if (!PENABLE) begin
            setup_n++;
            acc_n      = 0;
            cap_addr   = PADDR;
            cap_write  = PWRITE;
            cap_wdata  = PWDATA;
            cap_stable = 1'b1;
        end else begin
            acc_n++;
            last_acc = acc_n;
            if ({PADDR, PWRITE, PWDATA} !== {cap_addr, cap_write, cap_wdata}) cap_stable = 1'b0;
            if (acc_n > wait_n) begin
                PREADY  = 1'b1;
                PRDATA  = cur_rdata;
                PSLVERR = cur_err;
                if (acc_n == wait_n + 1)
                    log_q.push_back('{cap_addr, cap_write, cap_wdata, setup_n, acc_n, cap_stable, $time});
            end
        end
    end

    // tx decoder: sample mid-bit, record each byte, its start time and the stop-sample time.
    initial begin : tx_mon
        logic [7:0] b;
        time        t0;
        forever begin
            @(negedge PCLK);
            if (tx === 1'b0) begin
                t0 = $time;
                repeat (DIV / 2) @(negedge PCLK);
                if (tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (DIV) @(negedge PCLK);
                        b[i] = tx;
                    end
                    repeat (DIV) @(negedge PCLK);
                    if (tx === 1'b1) begin
                        rx_q.push_back(b);
                        start_q.push_back(t0);
                        stop_time = $time;
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (DIV) @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge PCLK);
        end
        rx = stop_ok;
        repeat (DIV) @(negedge PCLK);
        rx = 1'b1;
    endtask

    // Reply rules: W -> 'K', R -> 4 data bytes LSB first, slave error -> 'E', anything else -> '?'.
    function automatic void model(input logic [7:0] cmd, input logic [31:0] rdata, input logic err,
                                  output int n, output logic [31:0] bytes, output bit xfer);
        xfer  = (cmd == 8'h57) || (cmd == 8'h52);
        n     = 1;
        bytes = 32'h0000_003F;
        if (xfer && err)           bytes = 32'h0000_0045;
        else if (cmd == 8'h57)     bytes = 32'h0000_004B;
        else if (cmd == 8'h52) begin
            n     = 4;
            bytes = rdata;
        end
    endfunction

    task automatic run_txn(input string name, input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                           input logic err, input int exp_n, input logic [31:0] exp_bytes,
                           input bit exp_xfer);
        time t_fall;
        time lat;
        wait_n = waits;
        cur_rdata = rdata;
        cur_err = err;
        log_q.delete();
        rx_q.delete();
        start_q.delete();
        psel_cycles = 0;
        send_byte(cmd, 1'b1);
        if (cmd == 8'h57 || cmd == 8'h52) send_byte(addr, 1'b1);
        if (cmd == 8'h57) for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8], 1'b1);
        for (int i = 0; i < 2000 && rx_q.size() < exp_n; i++) @(negedge PCLK);
        t_fall = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                t_fall = $time;
                break;
            end
            @(negedge PCLK);
        end
        check({name, "_resp_count"}, rx_q.size(), exp_n);
        for (int i = 0; i < exp_n && i < rx_q.size(); i++)
            check({name, "_resp_byte"}, rx_q[i], exp_bytes[8*i +: 8]);
        check({name, "_busy_fall"}, t_fall - stop_time, 9 * PER);
        check({name, "_xfer_count"}, log_q.size(), exp_xfer);
        if (!exp_xfer) check({name, "_no_psel"}, psel_cycles, 0);
        if (exp_xfer && log_q.size() == 1) begin
            check({name, "_paddr"}, log_q[0].addr, addr);
            check({name, "_pwrite"}, log_q[0].write, cmd == 8'h57);
            check({name, "_pwdata"}, log_q[0].wdata, (cmd == 8'h57) ? wdata : 32'h0);
            check({name, "_setup_cycles"}, log_q[0].setup_n, 1);
            check({name, "_access_cycles"}, log_q[0].acc_n, waits + 1);
            check({name, "_stable"}, log_q[0].stable, 1);
            check({name, "_paddr_hold"}, PADDR, addr);
            lat = (start_q.size() > 0) ? start_q[0] - log_q[0].t_ready : 0;
            check({name, "_resp_latency_ok"}, (lat > 0) && (lat <= 3 * PER), 1);
        end
    endtask

    vec_t vecs[5];

    initial begin
        logic [7:0]  cmd, other, addr;
        logic [31:0] wdata, rdata, exp_bytes;
        logic        err;
        int          waits, exp_n;
        bit          exp_xfer;

        vecs[0] = '{"write",     8'h57, 8'h04, 32'h1234_5678, 32'h0,         0, 1'b0, 1, 32'h4B,        1'b1};
        vecs[1] = '{"read_wait", 8'h52, 8'h08, 32'h0,         32'hDEAD_BEEF, 3, 1'b0, 4, 32'hDEAD_BEEF, 1'b1};
        vecs[2] = '{"read_err",  8'h52, 8'h10, 32'h0,         32'h5555_AAAA, 1, 1'b1, 1, 32'h45,        1'b1};
        vecs[3] = '{"unknown",   8'h41, 8'h00, 32'h0,         32'h0,         0, 1'b0, 1, 32'h3F,        1'b0};
        vecs[4] = '{"write_err", 8'h57, 8'hFF, 32'hCAFE_F00D, 32'h0,         2, 1'b1, 1, 32'h45,        1'b1};

        repeat (3) @(negedge PCLK);
        check("reset_state", {tx, PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0});
        PRESETn = 1'b1;
        repeat (5) @(negedge PCLK);

        foreach (vecs[v])
            run_txn(vecs[v].name, vecs[v].cmd, vecs[v].addr, vecs[v].wdata, vecs[v].rdata,
                    vecs[v].waits, vecs[v].err, vecs[v].exp_n, vecs[v].exp_bytes, vecs[v].exp_xfer);

        // Framing error on the address byte: nothing happens, then a normal write goes through.
        log_q.delete();
        rx_q.delete();
        psel_cycles = 0;
        send_byte(8'h57, 1'b1);
        send_byte(8'h04, 1'b0);
        repeat (20 * DIV) @(negedge PCLK);
        check("ferr_no_psel", psel_cycles, 0);
        check("ferr_no_resp", rx_q.size(), 0);
        check("ferr_idle", busy, 1'b0);
        run_txn("after_ferr", 8'h57, 8'h0C, 32'h0BAD_F00D, 32'h0, 0, 1'b0, 1, 32'h4B, 1'b1);

        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 2))
                0:       cmd = 8'h57;
                1:       cmd = 8'h52;
                default: begin
                    do other = 8'($urandom_range(0, 255)); while (other == 8'h57 || other == 8'h52);
                    cmd = other;
                end
            endcase
            addr  = 8'($urandom_range(0, 255));
            wdata = $urandom;
            rdata = $urandom;
            waits = $urandom_range(0, 3);
            err   = ($urandom_range(0, 3) == 0);
            model(cmd, rdata, err, exp_n, exp_bytes, exp_xfer);
            run_txn("random", cmd, addr, wdata, rdata, waits, err, exp_n, exp_bytes, exp_xfer);
        end

`ifdef UART_APB_TIMEOUT_EN
        wait_n = 1_000_000;
        log_q.delete();
        rx_q.delete();
        send_byte(8'h52, 1'b1);
        send_byte(8'h40, 1'b1);
        for (int i = 0; i < 2000 && rx_q.size() < 1; i++) @(negedge PCLK);
        check("timeout_resp_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("timeout_resp_byte", rx_q[0], 8'h54);
        check("timeout_access_cycles", last_acc, TMO);
        check("timeout_no_ready_log", log_q.size(), 0);
        for (int i = 0; i < 40 && busy; i++) @(negedge PCLK);
        check("timeout_idle", busy, 1'b0);
`endif

        // Stall a read in ACCESS, then pull reset mid-transfer.
        wait_n = 1_000_000;
        send_byte(8'h52, 1'b1);
        send_byte(8'h30, 1'b1);
        for (int i = 0; i < 1000 && !(PSEL && PENABLE); i++) @(negedge PCLK);
        check("stall_reaches_access", PSEL && PENABLE, 1'b1);
`ifdef UART_APB_TIMEOUT_EN
        repeat (5) @(negedge PCLK);
`else
        repeat (1000) @(negedge PCLK);
        check("no_timeout_still_selected", {PSEL, PENABLE}, 2'b11);
`endif
        PRESETn = 1'b0;
        #1;
        check("async_reset_outputs", {PSEL, PENABLE, busy, tx}, 4'b0001);
        wait_n = 0;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (3) @(negedge PCLK);
        run_txn("post_reset_read", 8'h52, 8'h30, 32'h0, 32'h0123_4567, 0, 1'b0, 4, 32'h0123_4567, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_apb_bridge.md
# uart_apb_bridge

UART-to-APB bridge: the initiator end of the APB peripheral bus. The block receives command frames from a host on a UART RX line, issues single APB read or write transfers as bus master, and returns an acknowledgement or read data on UART TX. It sits between an external debug/host UART link and the APB peripheral fabric, including the UART APB slave, so a host can poke any 8-bit-addressed register.

## Interface
- `CLK_FREQ`, 50_000_000: PCLK frequency in Hz.
- `BAUD`, 115200: UART bit rate. Bit period `DIV = CLK_FREQ/BAUD` cycles, integer-truncated, DIV ≥ 4.
- `TIMEOUT`, 255: maximum ACCESS cycles (range 1-65535). Used only with `UART_APB_TIMEOUT_EN`.

- `PCLK` in 1: single clock.
- `PRESETn` in 1: asynchronous, active-low reset.
- `rx` in 1: UART serial input, asynchronous, idle high.
- `tx` out 1: UART serial output, idle high.
- `PSEL` out 1: APB select.
- `PENABLE` out 1: APB access phase.
- `PWRITE` out 1: 1 = write.
- `PADDR` out 8: APB address.
- `PWDATA` out 32: APB write data.
- `PRDATA` in 32: APB read data.
- `PREADY` in 1: completer ready.
- `PSLVERR` in 1: completer error, sampled with PREADY.
- `busy` out 1: high while a command is executing or its response is transmitting.

## Operation
- RX framing: 8N1, LSB first. `rx` passes through a 2-flop synchronizer. A falling edge starts a byte. The start bit is re-checked at DIV/2; if it is high, the detection is a glitch, the byte is ignored, and RX returns to idle. Data bits are sampled every DIV cycles thereafter. A stop bit sampled low is a framing error: the byte is discarded and the parser returns to CMD.
- Parser FSM: CMD → ADDR → DATA0..DATA3 (write only) → SETUP → ACCESS → RESP → IDLE-wait → CMD.
  - In CMD, 0x57 ('W') selects a write and 0x52 ('R') selects a read.
  - Any other byte in CMD skips the APB transfer and queues the response 0x3F ('?').
  - Write data arrives as 4 bytes, LSB first.
- `busy` rises on the cycle a valid command byte, or an unknown command byte, is accepted. It falls the cycle after the last response stop bit completes.
- While `busy`, the parser does not advance past the current frame. Bytes arriving in SETUP, ACCESS or RESP are dropped silently.
- APB master:
  - SETUP lasts one cycle with PSEL=1, PENABLE=0, and PADDR, PWRITE and PWDATA valid.
  - ACCESS has PSEL=1, PENABLE=1 and holds until PREADY=1 is sampled.
  - On that edge, PRDATA (reads) and PSLVERR are captured, and PSEL and PENABLE deassert on the next cycle.
  - PADDR, PWRITE and PWDATA stay stable from SETUP through ACCESS and hold their values afterward.
  - PWDATA is driven 0 on reads.
- Responses:
  - Write with no error: 0x4B ('K').
  - Read with no error: 4 bytes of PRDATA, LSB first.
  - PSLVERR=1: 0x45 ('E') only, with no data.
- TX: each byte is a 10-bit frame (start 0, data LSB first, stop 1), each bit DIV cycles. Multi-byte responses are sent back-to-back with no idle bits.

## Timing
- Reset values: tx=1, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, busy=0. The FSM resets to CMD.
- Reset asserted mid-transfer forces PSEL and PENABLE to 0 and tx to 1 immediately (asynchronously). The partial frame is lost.
- SETUP begins 1 cycle after the stop-bit sample of the final command byte (ADDR for reads, DATA3 for writes).
- With PREADY=1 already in ACCESS, a transfer is exactly 2 cycles (SETUP + ACCESS).
- The response start bit begins within 2 cycles of the ACCESS-completing edge. For an unknown command, it begins within 2 cycles of that byte's stop-bit sample.
- A new start bit on `rx` is recognised no earlier than the cycle `busy` falls.

## Configuration
- `UART_APB_TIMEOUT_EN` defined:
  - An ACCESS-cycle counter aborts the transfer when PREADY has been 0 for TIMEOUT consecutive ACCESS cycles.
  - On abort, PSEL and PENABLE drop on the next cycle, PRDATA is ignored, and the response is 0x54 ('T').
- Not defined: ACCESS waits on PREADY indefinitely, and no counter logic is present.

## Test plan
Use CLK_FREQ=1_600_000 and BAUD=100_000 (DIV=16) for simulation speed.
- Write: send 57 04 78 56 34 12 with PREADY=1 → one APB write, PADDR=0x04, PWDATA=0x12345678, 1 SETUP + 1 ACCESS cycle → tx sends 0x4B; busy falls after its stop bit.
- Read with wait states: send 52 08, PREADY low for 3 cycles, PRDATA=0xDEADBEEF → ACCESS lasts 4 cycles, PWDATA=0 → tx sends EF BE AD DE back-to-back.
- Error and unknown command: read with PSLVERR=1 → tx 0x45 only. Send 0x41 → tx 0x3F with no PSEL activity.
- Framing error: send 57, then 0x04 with the stop bit held low → no APB transfer and no response. A following valid write frame completes normally.
- Timeout (macro defined, TIMEOUT=16): read with PREADY stuck 0 → exactly 16 ACCESS cycles, PSEL low next cycle, tx 0x54. Without the macro, PSEL is still high after 1000 cycles.
- Reset during ACCESS: assert PRESETn=0 mid-ACCESS → PSEL, PENABLE and busy are 0 and tx is 1 immediately. After release, a fresh read frame completes correctly.
